// File: rtl/lag_stats_pkg.sv
// Shared types and constants for the lag tester statistics stage and its
// sequential binary-to-BCD converter.
package lag_stats_pkg;

  localparam int BCD_DIGITS   = 5;
  localparam int SAMPLE_BIN_W = 17;
  localparam int BCD_W        = 4 * BCD_DIGITS;
  localparam int DABBLE_W     = BCD_W + SAMPLE_BIN_W;

  typedef logic [BCD_W-1:0] bcd_word_t;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_CONV   = 2'd1,
    ST_UPDATE = 2'd2,
    ST_DABBLE = 2'd3
  } state_e;

  // One double-dabble iteration over {bcd digits, binary}: add 3 to every
  // digit >= 5, then shift the whole word left by one.
  function automatic logic [DABBLE_W-1:0] dabble_step(input logic [DABBLE_W-1:0] v);
    logic [DABBLE_W-1:0] t;
    t = v;
    for (int d = 0; d < BCD_DIGITS; d++) begin
      if (t[SAMPLE_BIN_W+4*d +: 4] >= 4'd5) begin
        t[SAMPLE_BIN_W+4*d +: 4] = t[SAMPLE_BIN_W+4*d +: 4] + 4'd3;
      end
    end
    return {t[DABBLE_W-2:0], 1'b0};
  endfunction

endpackage

// File: rtl/lag_stats_bin2bcd_seq.sv
// Sequential 17-bit binary to 5-digit BCD converter, one double-dabble step
// per cycle. The first step happens on the start edge; done pulses 17 cycles
// after start with bcd_o holding the result until the next conversion.
module bin2bcd_seq
  import lag_stats_pkg::*;
(
  input  logic        clock,
  input  logic        reset_n,
  input  logic        abort,
  input  logic        start,
  input  logic [16:0] bin_i,
  output logic        done,
  output logic [19:0] bcd_o
);

  logic [DABBLE_W-1:0] shift_q, shift_d, stepped;
  logic [4:0]          iter_q, iter_d;
  logic                run_q, run_d;
  logic                done_q, done_d;
  bcd_word_t           bcd_q, bcd_d;

  always_comb begin
    shift_d = shift_q;
    iter_d  = iter_q;
    run_d   = run_q;
    done_d  = 1'b0;
    bcd_d   = bcd_q;
    stepped = dabble_step(shift_q);
    if (abort) begin
      run_d  = 1'b0;
      iter_d = '0;
    end else if (start) begin
      shift_d = dabble_step({{BCD_W{1'b0}}, bin_i});
      iter_d  = 5'(SAMPLE_BIN_W - 1);
      run_d   = 1'b1;
    end else if (run_q) begin
      shift_d = stepped;
      iter_d  = iter_q - 5'd1;
      if (iter_q == 5'd1) begin
        run_d  = 1'b0;
        done_d = 1'b1;
        bcd_d  = stepped[DABBLE_W-1:SAMPLE_BIN_W];
      end
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      shift_q <= '0;
      iter_q  <= '0;
      run_q   <= 1'b0;
      done_q  <= 1'b0;
      bcd_q   <= '0;
    end else begin
      shift_q <= shift_d;
      iter_q  <= iter_d;
      run_q   <= run_d;
      done_q  <= done_d;
      bcd_q   <= bcd_d;
    end
  end

  assign done  = done_q;
  assign bcd_o = bcd_q;

endmodule

// File: rtl/lag_stats.sv
// Latency statistics: last/min/max and sliding-window average of BCD samples.
// Min/max tracking is present only when LAG_STATS_MINMAX_EN is defined.
module lag_stats
  import lag_stats_pkg::*;
#(
  parameter int WINDOW_LOG2 = 4
) (
  input  logic                 clock,
  input  logic                 reset_n,
  input  logic                 clear,
  input  logic                 sample_valid,
  input  logic [19:0]          sample_bcd,
  output logic                 busy,
  output logic [19:0]          last_bcd,
  output logic [19:0]          min_bcd,
  output logic [19:0]          max_bcd,
  output logic [19:0]          avg_bcd,
  output logic                 avg_valid,
  output logic [WINDOW_LOG2:0] count,
  output logic                 done,
  output logic                 bcd_error,
  output logic                 overrun,
  output logic [1:0]           dbg_state
);

  localparam int DEPTH = 1 << WINDOW_LOG2;
  localparam int SUM_W = SAMPLE_BIN_W + WINDOW_LOG2;
  localparam logic [WINDOW_LOG2:0] DEPTH_CNT = DEPTH[WINDOW_LOG2:0];

  state_e                  state_q, state_d;
  bcd_word_t               sample_q, sample_d, shift_q, shift_d;
  logic [SAMPLE_BIN_W-1:0] bin_q, bin_d, oldest;
  logic [2:0]              idx_q, idx_d;
  bcd_word_t               last_q, last_d, avg_q, avg_d;
  logic [SUM_W-1:0]        sum_q, sum_d, sum_next;
  logic [WINDOW_LOG2-1:0]  wr_ptr_q, wr_ptr_d;
  logic [WINDOW_LOG2:0]    count_q, count_d;
  logic                    avg_valid_q, avg_valid_d;
  logic                    done_q, done_d, err_q, err_d, overrun_q, overrun_d;
  logic                    ring_we, conv_start, conv_done, full;
  logic [3:0]              digit;
  bcd_word_t               conv_bcd;

  logic [SAMPLE_BIN_W-1:0] ring_mem [DEPTH];

  assign full = (count_q == DEPTH_CNT);

  always_comb begin
    state_d     = state_q;
    sample_d    = sample_q;
    shift_d     = shift_q;
    bin_d       = bin_q;
    idx_d       = idx_q;
    last_d      = last_q;
    sum_d       = sum_q;
    wr_ptr_d    = wr_ptr_q;
    count_d     = count_q;
    avg_d       = avg_q;
    avg_valid_d = avg_valid_q;
    done_d      = 1'b0;
    err_d       = 1'b0;
    overrun_d   = overrun_q;
    ring_we     = 1'b0;
    conv_start  = 1'b0;
    digit       = shift_q[19:16];
    // Until the window has wrapped, the slot being overwritten holds no sample.
    oldest      = full ? ring_mem[wr_ptr_q] : '0;
    sum_next    = sum_q + SUM_W'(bin_q) - SUM_W'(oldest);

    if (sample_valid && state_q != ST_IDLE) overrun_d = 1'b1;

    case (state_q)
      ST_IDLE: begin
        if (sample_valid) begin
          sample_d = sample_bcd;
          shift_d  = sample_bcd;
          bin_d    = '0;
          idx_d    = '0;
          state_d  = ST_CONV;
        end
      end
      ST_CONV: begin
        if (digit > 4'd9) begin
          err_d   = 1'b1;
          state_d = ST_IDLE;
        end else begin
          bin_d   = bin_q * 17'd10 + {13'd0, digit};
          shift_d = {shift_q[15:0], 4'h0};
          idx_d   = idx_q + 3'd1;
          if (idx_q == 3'd4) state_d = ST_UPDATE;
        end
      end
      ST_UPDATE: begin
        last_d     = sample_q;
        sum_d      = sum_next;
        ring_we    = 1'b1;
        wr_ptr_d   = wr_ptr_q + WINDOW_LOG2'(1);
        if (!full) count_d = count_q + (WINDOW_LOG2+1)'(1);
        conv_start = 1'b1;
        state_d    = ST_DABBLE;
      end
      ST_DABBLE: begin
        if (conv_done) begin
          avg_d       = full ? conv_bcd : '0;
          avg_valid_d = full;
          done_d      = 1'b1;
          state_d     = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase

    if (clear) begin
      state_d     = ST_IDLE;
      sample_d    = '0;
      shift_d     = '0;
      bin_d       = '0;
      idx_d       = '0;
      last_d      = '0;
      sum_d       = '0;
      wr_ptr_d    = '0;
      count_d     = '0;
      avg_d       = '0;
      avg_valid_d = 1'b0;
      done_d      = 1'b0;
      err_d       = 1'b0;
      overrun_d   = 1'b0;
      ring_we     = 1'b0;
      conv_start  = 1'b0;
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q     <= ST_IDLE;
      sample_q    <= '0;
      shift_q     <= '0;
      bin_q       <= '0;
      idx_q       <= '0;
      last_q      <= '0;
      sum_q       <= '0;
      wr_ptr_q    <= '0;
      count_q     <= '0;
      avg_q       <= '0;
      avg_valid_q <= 1'b0;
      done_q      <= 1'b0;
      err_q       <= 1'b0;
      overrun_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      sample_q    <= sample_d;
      shift_q     <= shift_d;
      bin_q       <= bin_d;
      idx_q       <= idx_d;
      last_q      <= last_d;
      sum_q       <= sum_d;
      wr_ptr_q    <= wr_ptr_d;
      count_q     <= count_d;
      avg_q       <= avg_d;
      avg_valid_q <= avg_valid_d;
      done_q      <= done_d;
      err_q       <= err_d;
      overrun_q   <= overrun_d;
    end
  end

  always_ff @(posedge clock) begin
    if (ring_we) ring_mem[wr_ptr_q] <= bin_q;
  end

  // Started from UPDATE with the freshly summed value so the result lands in
  // the last DABBLE cycle.
  bin2bcd_seq u_bin2bcd (
    .clock   (clock),
    .reset_n (reset_n),
    .abort   (clear),
    .start   (conv_start),
    .bin_i   (sum_next[SUM_W-1:WINDOW_LOG2]),
    .done    (conv_done),
    .bcd_o   (conv_bcd)
  );

`ifdef LAG_STATS_MINMAX_EN
  logic      mm_seen_q, mm_seen_d;
  bcd_word_t min_q, min_d, max_q, max_d;

  // BCD words compare in numeric order, so no conversion is needed here.
  always_comb begin
    mm_seen_d = mm_seen_q;
    min_d     = min_q;
    max_d     = max_q;
    if (state_q == ST_UPDATE) begin
      if (!mm_seen_q || sample_q < min_q) min_d = sample_q;
      if (!mm_seen_q || sample_q > max_q) max_d = sample_q;
      mm_seen_d = 1'b1;
    end
    if (clear) begin
      mm_seen_d = 1'b0;
      min_d     = '0;
      max_d     = '0;
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      mm_seen_q <= 1'b0;
      min_q     <= '0;
      max_q     <= '0;
    end else begin
      mm_seen_q <= mm_seen_d;
      min_q     <= min_d;
      max_q     <= max_d;
    end
  end

  assign min_bcd = min_q;
  assign max_bcd = max_q;
`else
  assign min_bcd = '0;
  assign max_bcd = '0;
`endif

  assign busy      = (state_q != ST_IDLE);
  assign last_bcd  = last_q;
  assign avg_bcd   = avg_q;
  assign avg_valid = avg_valid_q;
  assign count     = count_q;
  assign done      = done_q;
  assign bcd_error = err_q;
  assign overrun   = overrun_q;
  assign dbg_state = state_q;

endmodule

// File: tb/tb_lag_stats.sv
// Directed bench for lag_stats (WINDOW_LOG2 = 4); min/max expectations follow
// LAG_STATS_MINMAX_EN.
module tb_lag_stats;

  localparam int W = 4;
`ifdef LAG_STATS_MINMAX_EN
  localparam bit MM = 1'b1;
`else
  localparam bit MM = 1'b0;
`endif

  // clock / reset
  logic clock = 1'b0;
  logic reset_n = 1'b0;
  always #5 clock = ~clock;

  logic         clear = 1'b0;
  logic         sample_valid = 1'b0;
  logic [19:0]  sample_bcd = '0;
  logic         busy, avg_valid, done, bcd_error, overrun;
  logic [19:0]  last_bcd, min_bcd, max_bcd, avg_bcd;
  logic [W:0]   count;
  logic [1:0]   dbg_state;

  lag_stats #(.WINDOW_LOG2(W)) dut (
    .clock        (clock),
    .reset_n      (reset_n),
    .clear        (clear),
    .sample_valid (sample_valid),
    .sample_bcd   (sample_bcd),
    .busy         (busy),
    .last_bcd     (last_bcd),
    .min_bcd      (min_bcd),
    .max_bcd      (max_bcd),
    .avg_bcd      (avg_bcd),
    .avg_valid    (avg_valid),
    .count        (count),
    .done         (done),
    .bcd_error    (bcd_error),
    .overrun      (overrun),
    .dbg_state    (dbg_state)
  );

  // scoreboard
  int          n_checks = 0;
  int          n_fail = 0;
  logic [19:0] exp_q[$];
  int          r_done_cyc, r_err_cyc, r_n_done;
  logic        r_busy_ok;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [19:0] mm(input logic [19:0] v);
    return MM ? v : 20'h0;
  endfunction

  // Drives one sample in cycle 0, then observes cycles 1..30. An optional
  // extra sample_valid (kind 1) or clear (kind 2) is driven in cycle inj_cyc.
  task automatic run_sample(input logic [19:0] s, input int inj_cyc, input int inj_kind,
                            input logic [19:0] inj_val);
    r_done_cyc = -1;
    r_err_cyc  = -1;
    r_n_done   = 0;
    r_busy_ok  = 1'b1;
    @(posedge clock); #1;
    sample_valid = 1'b1;
    sample_bcd   = s;
    @(posedge clock); #1;
    sample_valid = 1'b0;
    for (int c = 1; c <= 30; c++) begin
      if (done === 1'b1) begin
        r_n_done++;
        if (r_done_cyc < 0) r_done_cyc = c;
      end
      if (bcd_error === 1'b1 && r_err_cyc < 0) r_err_cyc = c;
      if (r_done_cyc < 0 && r_err_cyc < 0 && !(inj_kind == 2 && c > inj_cyc) && busy !== 1'b1)
        r_busy_ok = 1'b0;
      if ((c == r_done_cyc || c == r_err_cyc) && busy !== 1'b0) r_busy_ok = 1'b0;
      sample_valid = (c == inj_cyc && inj_kind == 1);
      clear        = (c == inj_cyc && inj_kind == 2);
      sample_bcd   = inj_val;
      @(posedge clock); #1;
    end
    sample_valid = 1'b0;
    clear        = 1'b0;
  endtask

  task automatic accept(input string tag, input logic [19:0] s);
    exp_q.push_back(s);
    run_sample(s, 0, 0, 20'h0);
    check({tag, "_done_cyc"}, 32'(r_done_cyc), 32'd24);
    check({tag, "_n_done"}, 32'(r_n_done), 32'd1);
    check({tag, "_busy"}, 32'(r_busy_ok), 32'd1);
    check({tag, "_last"}, 32'(last_bcd), 32'(exp_q.pop_front()));
  endtask

  task automatic do_clear();
    @(posedge clock); #1;
    clear = 1'b1;
    @(posedge clock); #1;
    clear = 1'b0;
  endtask

  task automatic check_zero(input string tag);
    check({tag, "_busy"}, 32'(busy), 32'd0);
    check({tag, "_last"}, 32'(last_bcd), 32'd0);
    check({tag, "_min"}, 32'(min_bcd), 32'd0);
    check({tag, "_max"}, 32'(max_bcd), 32'd0);
    check({tag, "_avg"}, 32'(avg_bcd), 32'd0);
    check({tag, "_avg_valid"}, 32'(avg_valid), 32'd0);
    check({tag, "_count"}, 32'(count), 32'd0);
    check({tag, "_overrun"}, 32'(overrun), 32'd0);
  endtask

  initial begin
    // reset state
    repeat (3) @(posedge clock);
    #1;
    check_zero("reset");
    check("reset_done", 32'(done), 32'd0);
    check("reset_err", 32'(bcd_error), 32'd0);
    check("reset_state", 32'(dbg_state), 32'd0);
    reset_n = 1'b1;

    // three samples, window not yet full
    accept("s123", 20'h00123);
    accept("s456", 20'h00456);
    accept("s089", 20'h00089);
    check("three_min", 32'(min_bcd), 32'(mm(20'h00089)));
    check("three_max", 32'(max_bcd), 32'(mm(20'h00456)));
    check("three_count", 32'(count), 32'd3);
    check("three_avg_valid", 32'(avg_valid), 32'd0);
    check("three_avg", 32'(avg_bcd), 32'd0);

    // fill the 16-deep window
    do_clear();
    check("clr_count", 32'(count), 32'd0);
    for (int i = 0; i < 15; i++) accept("fill", 20'h01000);
    check("fill15_avg_valid", 32'(avg_valid), 32'd0);
    check("fill15_avg", 32'(avg_bcd), 32'd0);
    accept("fill16", 20'h01000);
    check("fill16_avg", 32'(avg_bcd), 32'h01000);
    check("fill16_avg_valid", 32'(avg_valid), 32'd1);
    check("fill16_count", 32'(count), 32'd16);
    accept("s1016", 20'h01016);
    check("s1016_avg", 32'(avg_bcd), 32'h01001);
    check("s1016_count", 32'(count), 32'd16);
    check("s1016_min", 32'(min_bcd), 32'(mm(20'h01000)));
    check("s1016_max", 32'(max_bcd), 32'(mm(20'h01016)));

    // bad BCD digit
    run_sample(20'h0A123, 0, 0, 20'h0);
    check("bad_err_cyc", 32'(r_err_cyc), 32'd3);
    check("bad_n_done", 32'(r_n_done), 32'd0);
    check("bad_busy", 32'(r_busy_ok), 32'd1);
    check("bad_last", 32'(last_bcd), 32'h01016);
    check("bad_count", 32'(count), 32'd16);
    check("bad_avg", 32'(avg_bcd), 32'h01001);

    // overrun: second sample_valid in cycle 10 is dropped
    exp_q.push_back(20'h00500);
    run_sample(20'h00500, 10, 1, 20'h00700);
    check("ovr_done_cyc", 32'(r_done_cyc), 32'd24);
    check("ovr_n_done", 32'(r_n_done), 32'd1);
    check("ovr_last", 32'(last_bcd), 32'(exp_q.pop_front()));
    check("ovr_flag", 32'(overrun), 32'd1);
    check("ovr_avg", 32'(avg_bcd), 32'h00969);
    check("ovr_min", 32'(min_bcd), 32'(mm(20'h00500)));
    check("ovr_max", 32'(max_bcd), 32'(mm(20'h01016)));

    // clear in cycle 12 aborts the sample
    run_sample(20'h00300, 12, 2, 20'h0);
    check("midclr_n_done", 32'(r_n_done), 32'd0);
    check_zero("midclr");
    accept("s99999", 20'h99999);
    check("s99999_min", 32'(min_bcd), 32'(mm(20'h99999)));
    check("s99999_max", 32'(max_bcd), 32'(mm(20'h99999)));
    check("s99999_count", 32'(count), 32'd1);
    check("s99999_avg", 32'(avg_bcd), 32'd0);

    // clear and sample_valid together: clear wins
    @(posedge clock); #1;
    clear = 1'b1;
    sample_valid = 1'b1;
    sample_bcd = 20'h00777;
    @(posedge clock); #1;
    clear = 1'b0;
    sample_valid = 1'b0;
    check_zero("clr_sv");

    accept("s500", 20'h00500);
    accept("s200", 20'h00200);
    check("s200_min", 32'(min_bcd), 32'(mm(20'h00200)));
    check("s200_max", 32'(max_bcd), 32'(mm(20'h00500)));
    check("s200_count", 32'(count), 32'd2);

    // asynchronous reset mid-operation
    @(posedge clock); #1;
    sample_valid = 1'b1;
    sample_bcd = 20'h00321;
    @(posedge clock); #1;
    sample_valid = 1'b0;
    repeat (7) @(posedge clock);
    #3;
    reset_n = 1'b0;
    #1;
    check_zero("areset");
    check("areset_state", 32'(dbg_state), 32'd0);
    #2;
    reset_n = 1'b1;
    repeat (2) @(posedge clock);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/lag_stats.md
# lag_stats

Statistics stage downstream of the latency capture register in the lag tester. It consumes each captured 5‑digit BCD latency sample (units of 0.01 ms, range 000.00–999.99 ms) and keeps last, minimum and maximum values plus a sliding‑window average. All results are presented in BCD for the on‑screen overlay. Runs entirely in the 27 MHz `clock` domain.

## Interface
- `WINDOW_LOG2`, 4, log2 of averaging window depth (window = 2^WINDOW_LOG2 samples, 1..6)
- `clock`  in  1  27 MHz system clock
- `reset_n`  in  1  asynchronous, active‑low reset
- `clear`  in  1  synchronous statistics clear; priority over everything except reset
- `sample_valid`  in  1  one‑cycle pulse; `sample_bcd` valid
- `sample_bcd`  in  20  5 BCD digits, [19:16] most significant
- `busy`  out  1  high while a sample is being processed; samples are not accepted
- `last_bcd`  out  20  most recent accepted sample
- `min_bcd` / `max_bcd`  out  20  extremes since last clear
- `avg_bcd`  out  20  window average, truncated
- `avg_valid`  out  1  window full; `avg_bcd` meaningful
- `count`  out  WINDOW_LOG2+1  accepted samples, saturating at 2^WINDOW_LOG2
- `done`  out  1  one‑cycle pulse: all outputs updated for the current sample
- `bcd_error`  out  1  one‑cycle pulse: sample rejected (digit > 9)
- `overrun`  out  1  sticky: `sample_valid` arrived while `busy`; cleared by `clear`

## Operation
- FSM states: IDLE, CONV, UPDATE, DABBLE.
- IDLE: on `sample_valid`, latch `sample_bcd` and go to CONV.
- CONV: 5 cycles, one digit per cycle, MSD first, `bin = bin*10 + digit` (17‑bit).
  - If any digit is > 9, pulse `bcd_error` on the cycle after the bad digit is seen, discard the sample and return to IDLE.
  - A rejected sample changes no statistics.
- UPDATE: 1 cycle.
  - `last_bcd` ← sample.
  - `min_bcd`/`max_bcd` update by direct compare of BCD words; BCD ordering equals numeric ordering.
  - The first sample after clear/reset sets both min and max.
  - Ring buffer of 2^WINDOW_LOG2 × 17‑bit entries: `sum ← sum + new − oldest`, where oldest counts as 0 until the buffer is full. Write pointer wraps modulo depth.
  - Sum width is 17+WINDOW_LOG2 bits and never overflows.
  - `count` increments, saturating.
- DABBLE: 17‑iteration double‑dabble of `sum >> WINDOW_LOG2`.
  - `avg_bcd` and `avg_valid` update together at exit, then `done` pulses and the FSM returns to IDLE.
  - Before the window is full: `avg_bcd` = 0 and `avg_valid` = 0.
- `sample_valid` while `busy`: sample dropped, `overrun` set, in‑flight work continues.
- `clear`:
  - Zeroes all statistics, `count`, ring buffer, sum, `overrun` and pointers; FSM → IDLE.
  - Mid‑operation clear aborts the sample with no `done`.
  - `clear` and `sample_valid` in the same cycle: clear wins, sample dropped, `overrun` not set.
- Ring buffer clear: a valid bit per entry, or a pointer‑based full flag. RAM contents need not be zeroed.

## Timing
- Reset values: all outputs 0; FSM IDLE; `min_bcd`/`max_bcd` marked empty.
- Accepted `sample_valid` at cycle 0:
  - `busy` high cycles 1–23.
  - CONV cycles 1–5, UPDATE cycle 6.
  - `last_bcd`/`min_bcd`/`max_bcd`/`count` visible from cycle 7.
  - DABBLE cycles 7–23.
  - `avg_bcd`/`avg_valid` visible and `done` high in cycle 24.
- `busy` is low in the `done` cycle, so a new sample is accepted there. Minimum sample spacing is 24 cycles.
- `bcd_error` latency: 1 cycle after the offending digit's CONV cycle; `busy` drops in the same cycle.
- Asynchronous reset mid‑operation: everything returns to reset values immediately.

## Configuration
- `LAG_STATS_MINMAX_EN` defined: min/max tracking as above.
- Not defined: min/max logic is removed, `min_bcd`/`max_bcd` are tied to 0, and all timing is unchanged.

## Structure
- Shared package holds:
  - FSM state enum.
  - `BCD_DIGITS` = 5 and `SAMPLE_BIN_W` = 17 constants.
  - BCD word typedef (20‑bit).
- One sub‑module, `bin2bcd_seq`: start/done handshake, 17‑bit binary in, 20‑bit BCD out, 17 cycles, reusable by the overlay.
- Ring buffer is inferred RAM inside `lag_stats`.

## Test plan
- Reset, then samples 00123, 00456, 00089 → `last_bcd` = 00089, `min_bcd` = 00089, `max_bcd` = 00456, `count` = 3, `avg_valid` = 0, `done` at cycle 24 each.
- 16 samples of 01000, then one of 01016 (WINDOW_LOG2 = 4) → after 16th: `avg_bcd` = 01000, `avg_valid` = 1; after 17th: `avg_bcd` = 01001.
- Sample 0A123 → `bcd_error` pulse at cycle 3, no `done`, statistics unchanged.
- Second `sample_valid` at cycle 10 of processing → `overrun` = 1, first sample completes normally, second ignored.
- `clear` asserted at cycle 12 of processing → no `done`, all outputs 0, next sample 99999 gives `min_bcd` = `max_bcd` = 99999.
- Build without `LAG_STATS_MINMAX_EN`, samples 00500, 00200 → `min_bcd` = `max_bcd` = 0, `last_bcd` = 00200, cycle timing identical.
